ysyx_22040895_lsu: RTL and testbench

//  Load/store unit: executes the memory access requested by the control unit's store/load decode (we, munit, unsigned).

---
 rtl/ysyx_22040895_lsu_pkg.sv | 18 +
 rtl/ysyx_22040895_lsu_align.sv | 51 +++++
 rtl/ysyx_22040895_lsu.sv | 179 +++++++++++++++++
 tb/tb_ysyx_22040895_lsu.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040895_lsu_pkg.sv
// Shared LSU definitions: access-size encodings, FSM states and default data width.
package ysyx_22040895_lsu_pkg;

  localparam int unsigned XLEN_DEF = 64;

  localparam logic [1:0] MUNIT_B = 2'b00;
  localparam logic [1:0] MUNIT_H = 2'b01;
  localparam logic [1:0] MUNIT_W = 2'b10;
  localparam logic [1:0] MUNIT_D = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/ysyx_22040895_lsu_align.sv
// Byte-lane steering for the LSU: store strobes/shift, load extract/extend, misalignment check.
module ysyx_22040895_lsu_align
  import ysyx_22040895_lsu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  localparam int unsigned MW   = XLEN / 8,
  localparam int unsigned OFFW = $clog2(MW)
) (
  input  logic [1:0]      i_munit,
  input  logic            i_unsigned,
  input  logic [OFFW-1:0] i_off,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  output logic [MW-1:0]   o_wmask_c,
  output logic [XLEN-1:0] o_wdata_c,
  output logic [XLEN-1:0] o_rdata_c,
  output logic            o_misaligned_c
);

  logic [XLEN-1:0] w_sh;

  assign w_sh      = i_rdata >> {i_off, 3'b000};
  assign o_wdata_c = i_wdata << {i_off, 3'b000};

  always_comb begin
    o_misaligned_c = 1'b0;
    o_wmask_c      = '1;
    o_rdata_c      = w_sh;
    case (i_munit)
      MUNIT_B: begin
        o_wmask_c = MW'(1) << i_off;
        o_rdata_c = i_unsigned ? XLEN'(w_sh[7:0]) : XLEN'($signed(w_sh[7:0]));
      end
      MUNIT_H: begin
        o_misaligned_c = i_off[0];
        o_wmask_c      = MW'(3) << i_off;
        o_rdata_c      = i_unsigned ? XLEN'(w_sh[15:0]) : XLEN'($signed(w_sh[15:0]));
      end
      MUNIT_W: begin
        o_misaligned_c = (i_off[1:0] != 2'b00);
        o_wmask_c      = MW'(4'hF) << i_off;
        o_rdata_c      = i_unsigned ? XLEN'(w_sh[31:0]) : XLEN'($signed(w_sh[31:0]));
      end
      default: begin
        // A doubleword access cannot exist on a 32-bit bus.
        o_misaligned_c = (XLEN == 32) ? 1'b1 : (i_off != '0);
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22040895_lsu.sv
// Load/store unit: request FSM between EX and the data bus.
// Optional bus watchdog enabled by defining YSYX_22040895_LSU_TIMEOUT_EN.
module ysyx_22040895_lsu
  import ysyx_22040895_lsu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
`ifdef YSYX_22040895_LSU_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid_i,
  input  logic              lsu_we_i,
  input  logic [1:0]        lsu_munit_i,
  input  logic              lsu_unsigned_i,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  output logic              lsu_ready_o,
  output logic              lsu_done_o,
  output logic [XLEN-1:0]   lsu_rdata_o,
  output logic              lsu_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_wmask_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int unsigned MW   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(MW);

  lsu_state_e      r_state;
  logic            r_we, r_unsigned, r_mis;
  logic [1:0]      r_munit;
  logic [OFFW-1:0] r_off;
  logic            r_ready, r_done, r_err, r_req, r_mem_we;
  logic [XLEN-1:0] r_rdata, r_addr, r_wdata;
  logic [MW-1:0]   r_wmask;

  logic            w_idle, w_unsigned, w_mis, w_to;
  logic [1:0]      w_munit;
  logic [OFFW-1:0] w_off;
  logic [MW-1:0]   w_wmask;
  logic [XLEN-1:0] w_wdata, w_rdata;

  // The aligner sees the live request while idle and the latched access afterwards.
  assign w_idle     = (r_state == S_IDLE);
  assign w_munit    = w_idle ? lsu_munit_i : r_munit;
  assign w_unsigned = w_idle ? lsu_unsigned_i : r_unsigned;
  assign w_off      = w_idle ? lsu_addr_i[OFFW-1:0] : r_off;

  ysyx_22040895_lsu_align #(.XLEN(XLEN)) u_align (
    .i_munit        (w_munit),
    .i_unsigned     (w_unsigned),
    .i_off          (w_off),
    .i_wdata        (lsu_wdata_i),
    .i_rdata        (mem_rdata_i),
    .o_wmask_c      (w_wmask),
    .o_wdata_c      (w_wdata),
    .o_rdata_c      (w_rdata),
    .o_misaligned_c (w_mis)
  );

`ifdef YSYX_22040895_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  assign w_to = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_idle && lsu_valid_i) begin
      r_cnt <= '0;
    end else if (r_state == S_REQ || r_state == S_RESP) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_mis      <= 1'b0;
      r_munit    <= MUNIT_B;
      r_off      <= '0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_req      <= 1'b0;
      r_mem_we   <= 1'b0;
      r_rdata    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (lsu_valid_i) begin
            r_we       <= lsu_we_i;
            r_munit    <= lsu_munit_i;
            r_unsigned <= lsu_unsigned_i;
            r_off      <= lsu_addr_i[OFFW-1:0];
            r_mis      <= w_mis;
            r_ready    <= 1'b0;
            // Misaligned accesses skip the bus and report one cycle later via RESP.
            if (w_mis) begin
              r_state <= S_RESP;
            end else begin
              r_state  <= S_REQ;
              r_req    <= 1'b1;
              r_mem_we <= lsu_we_i;
              r_addr   <= {lsu_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
              r_wdata  <= w_wdata;
              r_wmask  <= lsu_we_i ? w_wmask : '0;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            r_req    <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= S_RESP;
          end else if (w_to) begin
            r_req    <= 1'b0;
            r_mem_we <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_RESP: begin
          if (r_mis) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (mem_rvalid_i) begin
            r_rdata <= r_we ? '0 : w_rdata;
            r_err   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_to) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign lsu_ready_o = r_ready;
  assign lsu_done_o  = r_done;
  assign lsu_rdata_o = r_rdata;
  assign lsu_err_o   = r_err;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign mem_wmask_o = r_wmask;

endmodule

// File: tb/tb_ysyx_22040895_lsu.sv
// Scoreboard bench for ysyx_22040895_lsu (XLEN=64); timeout case under YSYX_22040895_LSU_TIMEOUT_EN.
module tb_ysyx_22040895_lsu;

  typedef struct {
    logic [63:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk, rst;
  logic        lsu_valid_i, lsu_we_i, lsu_unsigned_i;
  logic [1:0]  lsu_munit_i;
  logic [63:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_ready_o, lsu_done_o, lsu_err_o;
  logic [63:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [63:0] mem_rdata_i;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t sb_q[$];

`ifdef YSYX_22040895_LSU_TIMEOUT_EN
  ysyx_22040895_lsu #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut (
`else
  ysyx_22040895_lsu #(.XLEN(64)) dut (
`endif
    .clk(clk), .rst(rst),
    .lsu_valid_i(lsu_valid_i), .lsu_we_i(lsu_we_i), .lsu_munit_i(lsu_munit_i),
    .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_ready_o(lsu_ready_o), .lsu_done_o(lsu_done_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_err_o(lsu_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && lsu_done_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(lsu_done_o), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_rdata", lsu_rdata_o, e.rd);
        check("done_err", 64'(lsu_err_o), 64'(e.err));
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic access(input logic we, input logic [1:0] mu, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] bus_rd,
                        input int gnt_dly, input logic [63:0] exp_rd, input logic exp_err,
                        input logic [63:0] exp_addr, input logic [7:0] exp_mask,
                        input logic [63:0] exp_wd);
    exp_t e;
    bit   seen;
    check("ready_idle", 64'(lsu_ready_o), 64'd1);
    lsu_valid_i = 1'b1; lsu_we_i = we; lsu_munit_i = mu; lsu_unsigned_i = uns;
    lsu_addr_i = addr; lsu_wdata_i = wd;
    e.rd  = exp_rd;
    e.err = exp_err;
    e.cyc = exp_err ? cyc + 2 : cyc + 3 + gnt_dly;
    sb_q.push_back(e);
    @(negedge clk);
    lsu_valid_i = 1'b0;
    lsu_wdata_i = {$urandom, $urandom};
    if (!exp_err) begin
      for (int i = 0; i <= gnt_dly; i++) begin
        check("req", 64'(mem_req_o), 64'd1);
        check("req_we", 64'(mem_we_o), 64'(we));
        check("req_addr", mem_addr_o, exp_addr);
        check("req_wmask", 64'(mem_wmask_o), 64'(exp_mask));
        check("req_wdata", mem_wdata_o, exp_wd);
        check("busy", 64'(lsu_ready_o), 64'd0);
        if (i == gnt_dly) mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
      end
      check("resp_req_low", 64'(mem_req_o), 64'd0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = bus_rd;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = {$urandom, $urandom};
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (exp_err) check("mis_no_req", 64'(mem_req_o), 64'd0);
      if (lsu_done_o) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check("done_timeout", 64'(lsu_done_o), 64'd1);
    @(negedge clk);
    check("done_pulse", 64'(lsu_done_o), 64'd0);
    check("ready_after", 64'(lsu_ready_o), 64'd1);
    check("rdata_hold", lsu_rdata_o, exp_rd);
    check("err_hold", 64'(lsu_err_o), 64'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    lsu_valid_i = 1'b0; lsu_we_i = 1'b0; lsu_munit_i = 2'b00; lsu_unsigned_i = 1'b0;
    lsu_addr_i = '0; lsu_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(lsu_ready_o), 64'd1);
    check("rst_done", 64'(lsu_done_o), 64'd0);
    check("rst_err", 64'(lsu_err_o), 64'd0);
    check("rst_req", 64'(mem_req_o), 64'd0);
    check("rst_we", 64'(mem_we_o), 64'd0);
    check("rst_rdata", lsu_rdata_o, 64'd0);
    check("rst_addr", mem_addr_o, 64'd0);
    check("rst_wdata", mem_wdata_o, 64'd0);
    check("rst_wmask", 64'(mem_wmask_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // sb / lh / lhu / misaligned lw
    access(1, 2'b00, 0, 64'h1003, 64'hAB, 64'h0, 0,
           64'h0, 0, 64'h1000, 8'h08, 64'h0000_0000_AB00_0000);
    access(0, 2'b01, 0, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 0,
           64'hFFFF_FFFF_FFFF_8001, 0, 64'h2000, 8'h00, 64'h0);
    access(0, 2'b01, 1, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 0,
           64'h0000_0000_0000_8001, 0, 64'h2000, 8'h00, 64'h0);
    access(0, 2'b10, 0, 64'h3002, 64'h0, 64'h0, 0,
           64'h0, 1, 64'h0, 8'h00, 64'h0);
    // sw with grant held off 5 cycles
    access(1, 2'b10, 0, 64'h4004, 64'h1234_5678, 64'h0, 5,
           64'h0, 0, 64'h4000, 8'hF0, 64'h1234_5678_0000_0000);
    access(1, 2'b11, 0, 64'h5000, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 1,
           64'h0, 0, 64'h5000, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
    access(0, 2'b11, 1, 64'h6000, 64'h0, 64'h8000_0000_0000_0001, 2,
           64'h8000_0000_0000_0001, 0, 64'h6000, 8'h00, 64'h0);
    access(0, 2'b00, 0, 64'h7005, 64'h0, 64'h0000_8000_0000_0000, 0,
           64'hFFFF_FFFF_FFFF_FF80, 0, 64'h7000, 8'h00, 64'h0);
    access(0, 2'b00, 1, 64'h7005, 64'h0, 64'h0000_8000_0000_0000, 0,
           64'h0000_0000_0000_0080, 0, 64'h7000, 8'h00, 64'h0);
    access(0, 2'b10, 0, 64'h8004, 64'h0, 64'hF000_0001_0000_0000, 0,
           64'hFFFF_FFFF_F000_0001, 0, 64'h8000, 8'h00, 64'h0);
    access(0, 2'b10, 1, 64'h8004, 64'h0, 64'hF000_0001_0000_0000, 0,
           64'h0000_0000_F000_0001, 0, 64'h8000, 8'h00, 64'h0);
    access(0, 2'b11, 0, 64'h9004, 64'h0, 64'h0, 0,
           64'h0, 1, 64'h0, 8'h00, 64'h0);
    access(1, 2'b01, 0, 64'h9001, 64'h55AA, 64'h0, 0,
           64'h0, 1, 64'h0, 8'h00, 64'h0);
    access(1, 2'b01, 0, 64'h9002, 64'h55AA, 64'h0, 0,
           64'h0, 0, 64'h9000, 8'h0C, 64'h0000_0000_55AA_0000);

    // Stray response while idle must be ignored
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1111;
    repeat (2) @(negedge clk);
    mem_rvalid_i = 1'b0;
    check("stray_rvalid_ready", 64'(lsu_ready_o), 64'd1);
    check("stray_rvalid_done", 64'(lsu_done_o), 64'd0);

    // Reset during RESP: late response dropped, no done
    lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_munit_i = 2'b11; lsu_unsigned_i = 1'b0;
    lsu_addr_i = 64'hA000;
    @(negedge clk);
    lsu_valid_i = 1'b0;
    check("rstcase_req", 64'(mem_req_o), 64'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstcase_ready", 64'(lsu_ready_o), 64'd1);
    check("rstcase_req_low", 64'(mem_req_o), 64'd0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h2222;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    check("rstcase_no_done", 64'(lsu_done_o), 64'd0);
    @(negedge clk);
    check("rstcase_no_done2", 64'(lsu_done_o), 64'd0);
    access(0, 2'b11, 0, 64'hB008, 64'h0, 64'h0123_4567_89AB_CDEF, 0,
           64'h0123_4567_89AB_CDEF, 0, 64'hB008, 8'h00, 64'h0);

`ifdef YSYX_22040895_LSU_TIMEOUT_EN
    begin
      exp_t e;
      bit   seen;
      lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_munit_i = 2'b11; lsu_addr_i = 64'hC000;
      e.rd = 64'h0; e.err = 1'b1; e.cyc = cyc + 5;
      sb_q.push_back(e);
      @(negedge clk);
      lsu_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
        check("to_req", 64'(mem_req_o), 64'd1);
        @(negedge clk);
      end
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
        if (lsu_done_o) seen = 1'b1;
        else @(negedge clk);
      end
      if (!seen) check("to_done_timeout", 64'(lsu_done_o), 64'd1);
      @(negedge clk);
      check("to_ready", 64'(lsu_ready_o), 64'd1);
    end
`endif

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
